req_latch_sequencer: RTL and testbench

Collects single-cycle request pulses from up to WIDTH sources into sticky pending bits and presents them one at a time, highest index first, on a valid/ready grant channel. It sits directly upstream of the fixed-priority grant encoder: it keeps short requests alive until they are served and enforces the MSB-highest priority. It also counts requests lost because the source's bit was already pending.

---
 rtl/req_latch_sequencer.sv | 120 ++++++++++++
 tb/tb_req_latch_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/req_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : req_latch_sequencer
// Brief   : Latches request pulses into sticky pending bits and offers them
//           one at a time (highest index first) on a valid/ready grant channel.
// Revision: 1.0
// ============================================================================
module req_latch_sequencer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             flush,
    output logic [WIDTH-1:0] pending,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    input  logic             grant_ready,
    output logic [7:0]       drop_count
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       drop_q, drop_d;

    logic             accept;
    logic [WIDTH-1:0] accept_mask;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] drops;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   drop_cnt;
    logic [9:0]       drop_sum;

    // Datapath: accept mask, merged pending vector, drop popcount, priority select
    always_comb begin
        accept      = (state_q == S_OFFER) && grant_ready;
        accept_mask = '0;
        if (accept) begin
            accept_mask[idx_q] = 1'b1;
        end
        pending_next = (pending_q & ~accept_mask) | req_in;
        drops        = req_in & pending_q & ~accept_mask;

        drop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            drop_cnt = drop_cnt + {{IDX_W{1'b0}}, drops[i]};
        end
        drop_sum = {2'b00, drop_q} + 10'(drop_cnt);

        // Ascending scan so the last hit is the highest set bit
        sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_next[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        drop_d    = drop_q;

        if (flush) begin
            pending_d = '0;
            state_d   = S_IDLE;
        end else begin
            pending_d = pending_next;
            drop_d    = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
            case (state_q)
                S_IDLE: begin
                    if (pending_next != '0) begin
                        state_d = S_OFFER;
                        idx_d   = sel;
                    end
                end
                S_OFFER: begin
                    // Without a handshake the offer is frozen: no preemption
                    if (accept) begin
                        if (pending_next != '0) begin
                            idx_d = sel;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
        end
    end

    assign pending     = pending_q;
    assign grant_valid = (state_q == S_OFFER);
    assign grant_idx   = idx_q;
    assign drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_req_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_req_latch_sequencer
// Brief   : Directed self-checking bench for req_latch_sequencer.
// Revision: 1.0
// ============================================================================
module tb_req_latch_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       flush;
    logic [7:0] pending;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       grant_ready;
    logic [7:0] drop_count;

    int n_asserts = 0;
    int n_fail    = 0;

    req_latch_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .flush      (flush),
        .pending    (pending),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .grant_ready(grant_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pend, input logic e_v,
                           input logic [2:0] e_idx, input logic [7:0] e_drop);
        chk({tag, ".pending"},     32'(pending),     32'(e_pend));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(e_v));
        chk({tag, ".grant_idx"},   32'(grant_idx),   32'(e_idx));
        chk({tag, ".drop_count"},  32'(drop_count),  32'(e_drop));
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_in      = 8'h00;
        flush       = 1'b0;
        grant_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_all("reset", 8'h00, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle_after_reset", 8'h00, 1'b0, 3'd0, 8'h00);
        end

        // Priority order with ready held high
        grant_ready = 1'b1;
        req_in      = 8'hA1;
        tick();
        chk_all("prio_7", 8'hA1, 1'b1, 3'd7, 8'h00);
        req_in = 8'h00;
        tick();
        chk_all("prio_5", 8'h21, 1'b1, 3'd5, 8'h00);
        tick();
        chk_all("prio_0", 8'h01, 1'b1, 3'd0, 8'h00);
        tick();
        chk_all("prio_done", 8'h00, 1'b0, 3'd0, 8'h00);

        // No preemption
        grant_ready = 1'b0;
        req_in      = 8'h02;
        tick();
        chk_all("nopre_offer1", 8'h02, 1'b1, 3'd1, 8'h00);
        req_in = 8'h80;
        tick();
        chk_all("nopre_hold1", 8'h82, 1'b1, 3'd1, 8'h00);
        req_in = 8'h00;
        tick();
        chk_all("nopre_still1", 8'h82, 1'b1, 3'd1, 8'h00);
        grant_ready = 1'b1;
        tick();
        chk_all("nopre_acc1", 8'h80, 1'b1, 3'd7, 8'h00);
        tick();
        chk_all("nopre_acc7", 8'h00, 1'b0, 3'd7, 8'h00);

        // Drops on a pending, unaccepted bit 3
        grant_ready = 1'b0;
        req_in      = 8'h08;
        tick();
        chk_all("drop_offer3", 8'h08, 1'b1, 3'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            req_in = 8'h08;
            tick();
            req_in = 8'h00;
            tick();
        end
        chk_all("drop_three", 8'h08, 1'b1, 3'd3, 8'h03);

        // Request on the bit being accepted: not a drop, re-offered
        grant_ready = 1'b1;
        req_in      = 8'h08;
        tick();
        chk_all("same_cycle_accept", 8'h08, 1'b1, 3'd3, 8'h03);

        // Multi-bit drop vector: only bit 3 already pending
        grant_ready = 1'b0;
        req_in      = 8'h0C;
        tick();
        chk_all("drop_multi_a", 8'h0C, 1'b1, 3'd3, 8'h04);
        tick();
        chk_all("drop_multi_b", 8'h0C, 1'b1, 3'd3, 8'h06);

        req_in = 8'h08;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        chk_all("drop_saturate", 8'h0C, 1'b1, 3'd3, 8'hFF);
        req_in      = 8'h00;
        grant_ready = 1'b1;
        tick();
        chk_all("drain_3", 8'h04, 1'b1, 3'd2, 8'hFF);
        tick();
        chk_all("drain_2", 8'h00, 1'b0, 3'd2, 8'hFF);

        // Asynchronous reset while an offer is up
        grant_ready = 1'b0;
        req_in      = 8'h55;
        tick();
        chk_all("pre_reset_offer", 8'h55, 1'b1, 3'd6, 8'hFF);
        req_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_reset", 8'h00, 1'b0, 3'd0, 8'h00);

        // Flush with a coinciding request on bit 7
        req_in = 8'h55;
        tick();
        chk_all("flush_setup", 8'h55, 1'b1, 3'd6, 8'h00);
        req_in = 8'h04;
        tick();
        chk_all("flush_predrop", 8'h55, 1'b1, 3'd6, 8'h01);
        req_in = 8'h80;
        flush  = 1'b1;
        tick();
        chk_all("flush", 8'h00, 1'b0, 3'd6, 8'h01);
        req_in      = 8'h00;
        flush       = 1'b0;
        grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("after_flush", 8'h00, 1'b0, 3'd6, 8'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
